// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: opcode/handshake inputs and datapath control outputs of the multicycle control unit.
interface multicycle_control_unit_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
    logic             IRWrite, ALUSrcA, RegWrite, RegDst, BranchNE;
    logic [1:0]       PCSource, ALUOp, ALUSrcB;
    logic [3:0]       state;
    logic             instr_done, illegal_op;
    logic [CNT_W-1:0] retired;
    modport master (
        input  opcode, mem_ready,
        output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
               RegWrite, RegDst, BranchNE, PCSource, ALUOp, ALUSrcB, state, instr_done,
               illegal_op, retired
    );
    modport slave (
        output opcode, mem_ready,
        input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
               RegWrite, RegDst, BranchNE, PCSource, ALUOp, ALUSrcB, state, instr_done,
               illegal_op, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle MIPS control FSM with memory-ready stretching, addi/bne, illegal-op detection and retire counter.
module multicycle_control_unit #(
    parameter bit EN_EXT = 1'b1,
    parameter int CNT_W  = 32
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BEQ = 4'd8, JUMP = 4'd9,
        ADDI_EX = 4'd10, ADDI_WB = 4'd11, BNE = 4'd12
    } state_t;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000, OP_BNE = 6'b000101;
    state_t state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;
    always_comb begin
        state_d         = state_q;
        bus.PCWriteCond = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.BranchNE    = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.instr_done  = 1'b0;
        bus.illegal_op  = 1'b0;
        // Outputs stay at their defaults while reset is high.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                    state_d     = bus.mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                              (bus.opcode == OP_R)                          ? EXEC   :
                              (bus.opcode == OP_BEQ)                        ? BEQ    :
                              (bus.opcode == OP_J)                          ? JUMP   :
                              (EN_EXT && bus.opcode == OP_ADDI)             ? ADDI_EX :
                              (EN_EXT && bus.opcode == OP_BNE)              ? BNE    : FETCH;
                    bus.illegal_op = (state_d == FETCH);
                end
                MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    state_d     = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    bus.MemRead = 1'b1;
                    bus.IorD    = 1'b1;
                    state_d     = bus.mem_ready ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.MemtoReg   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
                MEMWR: begin
                    bus.MemWrite   = 1'b1;
                    bus.IorD       = 1'b1;
                    bus.instr_done = bus.mem_ready;
                    state_d        = bus.mem_ready ? FETCH : MEMWR;
                end
                EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                    state_d     = RWB;
                end
                RWB: begin
                    bus.RegWrite   = 1'b1;
                    bus.RegDst     = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
                BEQ, BNE: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                    bus.BranchNE    = (state_q == BNE);
                    bus.instr_done  = 1'b1;
                    state_d         = FETCH;
                end
                JUMP: begin
                    bus.PCWrite    = 1'b1;
                    bus.PCSource   = 2'b10;
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
                ADDI_EX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    state_d     = ADDI_WB;
                end
                ADDI_WB: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                    state_d        = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (bus.instr_done) retired_q <= retired_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed scoreboard bench; per-cycle expectations are queued by stimulus and checked by a negedge monitor.
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;
    multicycle_control_unit_if #(.CNT_W(32)) i0();
    multicycle_control_unit_if #(.CNT_W(4))  i1();
    multicycle_control_unit #(.EN_EXT(1'b1), .CNT_W(32)) dut0 (.clk(clk), .reset(rst0), .bus(i0.master));
    multicycle_control_unit #(.EN_EXT(1'b0), .CNT_W(4))  dut1 (.clk(clk), .reset(rst1), .bus(i1.master));
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BQ = 6'b000100;
    localparam logic [5:0] JP = 6'b000010, AD = 6'b001000, BN = 6'b000101, BAD = 6'b111111;
    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MW = 4'd5;
    localparam logic [3:0] EX = 4'd6, RW = 4'd7, BEQS = 4'd8, JS = 4'd9, AEX = 4'd10, AWB = 4'd11, BNES = 4'd12;
    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [31:0] ret;
    } exp_t;
    exp_t q0[$], q1[$];
    int tests = 0, fails = 0;
    int ret[2];
    logic [18:0] a0, a1;
    // {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUOp,ALUSrcB,BranchNE,instr_done,illegal_op}
    assign a0 = {i0.PCWriteCond, i0.PCWrite, i0.IorD, i0.MemRead, i0.MemWrite, i0.MemtoReg, i0.IRWrite,
                 i0.ALUSrcA, i0.RegWrite, i0.RegDst, i0.PCSource, i0.ALUOp, i0.ALUSrcB,
                 i0.BranchNE, i0.instr_done, i0.illegal_op};
    assign a1 = {i1.PCWriteCond, i1.PCWrite, i1.IorD, i1.MemRead, i1.MemWrite, i1.MemtoReg, i1.IRWrite,
                 i1.ALUSrcA, i1.RegWrite, i1.RegDst, i1.PCSource, i1.ALUOp, i1.ALUSrcB,
                 i1.BranchNE, i1.instr_done, i1.illegal_op};
    function automatic logic [18:0] ectl(input logic [3:0] s, input logic mr, input logic ill);
        case (s)
            F:       ectl = mr ? 19'b0101001000_00_00_01_000 : 19'b0001000000_00_00_01_000;
            D:       ectl = ill ? 19'b0000000000_00_00_11_001 : 19'b0000000000_00_00_11_000;
            MA:      ectl = 19'b0000000100_00_00_10_000;
            MR:      ectl = 19'b0011000000_00_00_00_000;
            MWB:     ectl = 19'b0000010010_00_00_00_010;
            MW:      ectl = mr ? 19'b0010100000_00_00_00_010 : 19'b0010100000_00_00_00_000;
            EX:      ectl = 19'b0000000100_00_10_00_000;
            RW:      ectl = 19'b0000000011_00_00_00_010;
            BEQS:    ectl = 19'b1000000100_01_01_00_010;
            JS:      ectl = 19'b0100000000_10_00_00_010;
            AEX:     ectl = 19'b0000000100_00_00_10_000;
            AWB:     ectl = 19'b0000000010_00_00_00_010;
            BNES:    ectl = 19'b1000000100_01_01_00_110;
            default: ectl = '0;
        endcase
    endfunction
    task automatic cyc(input int d, input string tag, input logic [5:0] op, input logic mr,
                       input logic rs, input logic [3:0] st, input logic ill = 1'b0);
        exp_t e;
        @(posedge clk);
        #1;
        if (d == 0) begin
            i0.opcode = op; i0.mem_ready = mr; rst0 = rs;
        end else begin
            i1.opcode = op; i1.mem_ready = mr; rst1 = rs;
        end
        e.tag = tag;
        e.st  = st;
        e.ctl = rs ? 19'd0 : ectl(st, mr, ill);
        e.ret = (d == 1) ? 32'(ret[d] % 16) : 32'(ret[d]);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        if (rs) ret[d] = 0;
        else if (e.ctl[1]) ret[d]++;
    endtask
    task automatic chk(input int d, input exp_t e, input logic [3:0] st, input logic [18:0] ctl, input logic [31:0] r);
        tests++;
        if (st !== e.st || ctl !== e.ctl || r !== e.ret) begin
            fails++;
            $display("FAIL dut%0d %s: got state=%0d ctl=%b retired=%0d, want state=%0d ctl=%b retired=%0d",
                     d, e.tag, st, ctl, r, e.st, e.ctl, e.ret);
        end
    endtask
    always @(negedge clk) begin
        if (q0.size() > 0) chk(0, q0.pop_front(), i0.state, a0, i0.retired);
        if (q1.size() > 0) chk(1, q1.pop_front(), i1.state, a1, 32'(i1.retired));
    end
    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        i0.opcode = '0; i0.mem_ready = 1'b0;
        i1.opcode = '0; i1.mem_ready = 1'b0;
        ret[0] = 0; ret[1] = 0;
        cyc(0, "reset", LW, 1, 1, F);
        foreach (ret[k]) ret[k] = 0;
        cyc(0, "lw", LW, 1, 0, F);  cyc(0, "lw", LW, 1, 0, D);  cyc(0, "lw", LW, 1, 0, MA);
        cyc(0, "lw", LW, 1, 0, MR); cyc(0, "lw", LW, 1, 0, MWB);
        cyc(0, "sw", SW, 1, 0, F);  cyc(0, "sw", SW, 1, 0, D);  cyc(0, "sw", SW, 1, 0, MA);
        for (int k = 0; k < 3; k++) cyc(0, "sw_wait", SW, 0, 0, MW);
        cyc(0, "sw_done", SW, 1, 0, MW);
        cyc(0, "rtype", RT, 1, 0, F); cyc(0, "rtype", RT, 1, 0, D);
        cyc(0, "rtype_opchg", BAD, 1, 0, EX); cyc(0, "rtype", RT, 1, 0, RW);
        cyc(0, "beq", BQ, 1, 0, F); cyc(0, "beq_mr0", BQ, 0, 0, D); cyc(0, "beq", BQ, 1, 0, BEQS);
        cyc(0, "j", JP, 1, 0, F); cyc(0, "j", JP, 1, 0, D); cyc(0, "j", JP, 1, 0, JS);
        cyc(0, "addi", AD, 1, 0, F); cyc(0, "addi", AD, 1, 0, D);
        cyc(0, "addi", AD, 1, 0, AEX); cyc(0, "addi", AD, 1, 0, AWB);
        cyc(0, "bne", BN, 1, 0, F); cyc(0, "bne", BN, 1, 0, D); cyc(0, "bne", BN, 1, 0, BNES);
        cyc(0, "illegal", BAD, 1, 0, F); cyc(0, "illegal", BAD, 1, 0, D, 1'b1);
        cyc(0, "fetch_wait", LW, 0, 0, F); cyc(0, "lw2", LW, 1, 0, F); cyc(0, "lw2", LW, 1, 0, D);
        cyc(0, "lw2", LW, 1, 0, MA); cyc(0, "memrd_wait", LW, 0, 0, MR); cyc(0, "lw2", LW, 1, 0, MR);
        cyc(0, "lw2", LW, 1, 0, MWB);
        cyc(0, "abort", LW, 1, 0, F); cyc(0, "abort", LW, 1, 0, D); cyc(0, "abort", LW, 1, 0, MA);
        cyc(0, "abort", LW, 0, 0, MR);
        cyc(0, "rst_memrd", LW, 1, 1, MR); cyc(0, "rst_hold", LW, 1, 1, F);
        cyc(0, "post_rst", JP, 1, 0, F); cyc(0, "post_rst", JP, 1, 0, D); cyc(0, "post_rst", JP, 1, 0, JS);
        cyc(0, "post_rst_cnt", JP, 0, 0, F);
        @(posedge clk); #1; rst0 = 1'b1;
        cyc(1, "reset1", AD, 1, 1, F);
        cyc(1, "noext_addi", AD, 1, 0, F); cyc(1, "noext_addi", AD, 1, 0, D, 1'b1);
        cyc(1, "noext_bne", BN, 1, 0, F);  cyc(1, "noext_bne", BN, 1, 0, D, 1'b1);
        for (int k = 0; k < 17; k++) begin
            cyc(1, "wrap_j", JP, 1, 0, F); cyc(1, "wrap_j", JP, 1, 0, D); cyc(1, "wrap_j", JP, 1, 0, JS);
        end
        cyc(1, "wrap_cnt", JP, 0, 0, F);
        for (int k = 0; k < 20 && (q0.size() > 0 || q1.size() > 0); k++) @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d/%0d expectations left, want 0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Parametrised multicycle MIPS control unit. It drives the datapath mux selects, memory strobes and write enables of the multicycle processor top level from the instruction-register opcode. Compared with the original control FSM it adds:
- synchronous reset;
- a memory-ready handshake that stretches every memory state;
- optional `addi`/`bne` support;
- illegal-opcode detection;
- a retired-instruction counter.

## Interface
Parameters:
- `EN_EXT`, 1: 1 decodes `addi` (001000) and `bne` (000101); 0 treats both as illegal.
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  Instruction[31:26] from the instruction register; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `PCWriteCond`, `PCWrite`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  standard multicycle controls.
- `PCSource`, `ALUOp`, `ALUSrcB`  out  2 each  mux selects and ALU op class.
- `BranchNE`  out  1  inverts Zero in the PC-write condition logic.
- `state`  out  4  current state encoding, for debug.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each legal instruction.
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `retired`  out  CNT_W  count of completed instructions.

## Operation
State encodings:
- 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RWB, 8 BEQ, 9 JUMP, 10 ADDI_EX, 11 ADDI_WB, 12 BNE.

Selector encodings:
- ALUSrcB: 00 reg B, 01 constant 4, 10 sign-extend, 11 sign-extend<<2.
- PCSource: 00 ALU result, 01 ALUOut, 10 jump concatenation.
- ALUOp: 00 add, 01 subtract, 10 funct field.

Per-state outputs (Moore; every signal not listed is 0):
- FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=mem_ready. Go to DECODE on mem_ready, else stay.
- DECODE: ALUSrcB=11. Next state by opcode:
  - 100011 or 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BEQ
  - 000010 → JUMP
  - 001000 → ADDI_EX (EN_EXT=1)
  - 000101 → BNE (EN_EXT=1)
  - anything else → FETCH, with illegal_op=1 this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10. lw → MEMRD; sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Go to MEMWB on mem_ready, else stay.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 → FETCH.
- MEMWR: MemWrite=1, IorD=1. Go to FETCH on mem_ready; instr_done only in that cycle.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RWB.
- RWB: RegWrite=1, RegDst=1 → FETCH.
- BEQ: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- BNE: as BEQ, plus BranchNE=1 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10 → ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 → FETCH.

Completion and counting:
- instr_done=1 in MEMWB, RWB, BEQ, BNE, JUMP, ADDI_WB, and in MEMWR when mem_ready=1.
- `retired` increments by 1 on every instr_done cycle and wraps modulo 2^CNT_W.
- Illegal opcodes are not counted. PC was already advanced in FETCH, so the illegal instruction is skipped.

## Timing
Reset:
- While reset=1, every control output, instr_done and illegal_op are forced to 0; state←FETCH and retired←0 at the clock edge.
- Reset mid-instruction aborts it with no instr_done and no count.
- The first cycle after reset falls is FETCH.

Latency with mem_ready held at 1:
- lw 5 cycles; sw 4; R-type 4; addi 4; beq/bne 3; j 3; illegal 2.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- While waiting, all outputs hold their values, except IRWrite/PCWrite in FETCH, which stay 0 until the ready cycle.

Handshake and strobes:
- mem_ready is ignored in all non-memory states.
- MemWrite stays asserted for the whole MEMWR dwell. Memory must treat it as level-sensitive and take a single write on the ready cycle.
- `opcode` is sampled only in DECODE and MEMADR; changes elsewhere have no effect.

## Test plan
- Reset then lw (100011), mem_ready=1 → states 0,1,2,3,4,0; instr_done only in MEMWB; retired=1; RegWrite=MemtoReg=1 in MEMWB only.
- sw with mem_ready low for 3 cycles in MEMWR → MemWrite=1 for 4 cycles; instr_done on the 4th; total 7 cycles.
- R-type then beq then j → EXEC has ALUOp=10, BEQ has ALUOp=01 with PCWriteCond=1, JUMP has PCSource=10; retired=3 after 10 cycles.
- EN_EXT=0, opcode 001000 → illegal_op pulse in DECODE, return to FETCH, retired unchanged. With EN_EXT=1 the same opcode gives ADDI_EX then ADDI_WB.
- CNT_W=4: 17 j instructions → retired wraps to 1.
- Reset asserted in MEMRD → next cycle all outputs 0; after release state=FETCH, retired=0, no instr_done.
